// File: rtl/rr_serial_encoder_pkg.sv
// Shared types and helpers for the round-robin serial encoder and its picker.
package rr_serial_encoder_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_serial_encoder_if.sv
// Request/handshake bundle between a request source/consumer and the encoder.
interface rr_serial_encoder_if #(
  parameter int N = 8
);
  import rr_serial_encoder_pkg::*;

  localparam int W = clog2(N);

  logic [N-1:0] req;
  logic         en;
  logic         out_ready;
  logic         out_valid;
  logic [W-1:0] out_idx;
  logic [W:0]   pend_cnt;
  logic         busy;

  modport master (
    output req, en, out_ready,
    input  out_valid, out_idx, pend_cnt, busy
  );

  modport slave (
    input  req, en, out_ready,
    output out_valid, out_idx, pend_cnt, busy
  );

endinterface

// File: rtl/rr_serial_encoder_pick.sv
// Round-robin find-first: lowest set bit of vec at or after ptr, wrapping at N.
module rr_pick
  import rr_serial_encoder_pkg::*;
#(
  parameter  int N = 8,
  localparam int W = clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] sel,
  output logic         any
);

  // Walk offsets from farthest to nearest so the nearest set bit wins.
  always_comb begin
    int j;
    sel = '0;
    any = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      j = k + int'(ptr);
      if (j >= N) j = j - N;
      if (vec[j]) begin
        sel = W'(j);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_serial_encoder.sv
// Turns a multi-hot request vector into a serial stream of indices, one per
// handshake, with round-robin selection so no request line can starve.
//
//   state | meaning
//   IDLE  | out_valid=0, nothing held for the consumer
//   GRANT | out_valid=1, out_idx holds a granted index awaiting out_ready
module rr_serial_encoder
  import rr_serial_encoder_pkg::*;
#(
  parameter int N = 8
) (
  input logic               clk,
  input logic               rst,
  rr_serial_encoder_if.slave bus
);

  localparam int W = clog2(N);

  state_t       state, state_n;
  logic [N-1:0] pend, pend_n, pend_eff;
  logic [W-1:0] ptr, ptr_n;
  logic [W-1:0] idx, idx_n;
  logic [W-1:0] sel;
  logic [W-1:0] ptr_inc;
  logic         any;
  logic         load;
  logic [W:0]   cnt;

  assign pend_eff = pend | (bus.en ? bus.req : '0);
  assign load     = (state == IDLE) | bus.out_ready;
  assign ptr_inc  = (sel == W'(N - 1)) ? '0 : sel + 1'b1;

  rr_pick #(.N(N)) u_pick (
    .vec (pend_eff),
    .ptr (ptr),
    .sel (sel),
    .any (any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pend  <= '0;
      ptr   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      pend  <= pend_n;
      ptr   <= ptr_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    pend_n  = pend;
    ptr_n   = ptr;
    idx_n   = idx;
    if (load) begin
      if (any) begin
        state_n = GRANT;
        idx_n   = sel;
        pend_n  = pend_eff & ~(N'(1) << sel);
        ptr_n   = ptr_inc;
      end else begin
        state_n = IDLE;
      end
    end else begin
      // Stalled: the held index stays put, new requests merge into pending.
      pend_n = pend_eff;
    end
  end

  always_comb begin
    cnt = '0;
    for (int i = 0; i < N; i++) begin
      cnt = cnt + (W + 1)'(pend[i]);
    end
  end

  assign bus.out_valid = (state == GRANT);
  assign bus.out_idx   = idx;
  assign bus.pend_cnt  = cnt;
  assign bus.busy      = (state == GRANT) | (|pend);

endmodule

// File: tb/tb_rr_serial_encoder.sv
// Scoreboard bench for rr_serial_encoder (N=8): expected indices are queued
// as requests are driven and popped on every accepted handshake.
module tb_rr_serial_encoder;

  localparam int N = 8;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sb[$];

  always #5 clk = ~clk;

  rr_serial_encoder_if #(.N(N)) bus ();

  rr_serial_encoder #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [N-1:0] r);
    bus.req = r;
    bus.en  = 1'b1;
    step();
    bus.req = '0;
    bus.en  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_cnt"},   int'(bus.pend_cnt), 0);
    chk({tag, "_busy"},  int'(bus.busy), 0);
    chk({tag, "_ptr"},   int'(dut.ptr), 0);
  endtask

  // Handshake monitor: sampled mid-cycle, the accept happens at the next edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      chk("sb_nonempty", int'(sb.size() > 0), 1);
      if (sb.size() > 0) chk("sb_idx", int'(bus.out_idx), sb.pop_front());
    end
  end

  initial begin
    bus.req       = '0;
    bus.en        = 1'b0;
    bus.out_ready = 1'b1;
    do_reset();
    chk_idle("reset");
    chk("reset_idx", int'(bus.out_idx), 0);

    // single-bit requests at 20 ns spacing
    for (int i = 0; i < 4; i++) begin
      sb.push_back(i);
      pulse(N'(1) << i);
      chk("single_valid", int'(bus.out_valid), 1);
      chk("single_idx", int'(bus.out_idx), i);
      step();
      chk("single_gap", int'(bus.out_valid), 0);
    end

    // multi-hot drain from ptr=0
    do_reset();
    sb.push_back(2); sb.push_back(4); sb.push_back(7);
    pulse(8'b1001_0100);
    chk("multi_cnt0", int'(bus.pend_cnt), 2);
    step();
    chk("multi_idx1", int'(bus.out_idx), 4);
    chk("multi_cnt1", int'(bus.pend_cnt), 1);
    step();
    chk("multi_idx2", int'(bus.out_idx), 7);
    chk("multi_busy2", int'(bus.busy), 1);
    step();
    chk_idle("multi_end");

    // rotation: after granting 2, ptr=3 so 5 precedes 1
    sb.push_back(2);
    pulse(8'b0000_0100);
    step();
    chk("rot_ptr", int'(dut.ptr), 3);
    sb.push_back(5); sb.push_back(1);
    pulse(8'b0010_0010);
    chk("rot_first", int'(bus.out_idx), 5);
    step();
    chk("rot_second", int'(bus.out_idx), 1);
    step();
    chk("rot_done", int'(bus.out_valid), 0);
    chk("rot_ptr2", int'(dut.ptr), 2);

    // requests without en, and en with no requests, do nothing
    bus.req = '1;
    bus.en  = 1'b0;
    step();
    bus.req = '0;
    chk("no_en_valid", int'(bus.out_valid), 0);
    chk("no_en_busy", int'(bus.busy), 0);
    pulse('0);
    chk("zero_req_valid", int'(bus.out_valid), 0);

    // backpressure with all lines requesting
    do_reset();
    bus.out_ready = 1'b0;
    for (int i = 0; i < N; i++) sb.push_back(i);
    pulse('1);
    chk("bp_valid", int'(bus.out_valid), 1);
    chk("bp_idx", int'(bus.out_idx), 0);
    chk("bp_cnt", int'(bus.pend_cnt), 7);
    step();
    chk("bp_hold_idx", int'(bus.out_idx), 0);
    chk("bp_hold_cnt", int'(bus.pend_cnt), 7);
    bus.out_ready = 1'b1;
    for (int i = 1; i < N; i++) begin
      step();
      chk("bp_seq_idx", int'(bus.out_idx), i);
      chk("bp_seq_cnt", int'(bus.pend_cnt), 7 - i);
    end
    step();
    chk_idle("bp_end");

    // merge during stall: 3 held, re-request 3 plus 6, then 6 again
    bus.out_ready = 1'b0;
    sb.push_back(3); sb.push_back(6); sb.push_back(3);
    pulse(8'b0000_1000);
    chk("merge_hold", int'(bus.out_idx), 3);
    pulse(8'b0100_1000);
    chk("merge_cnt", int'(bus.pend_cnt), 2);
    pulse(8'b0100_0000);
    chk("merge_dup_cnt", int'(bus.pend_cnt), 2);
    chk("merge_stable", int'(bus.out_idx), 3);
    bus.out_ready = 1'b1;
    step();
    chk("merge_idx1", int'(bus.out_idx), 6);
    step();
    chk("merge_idx2", int'(bus.out_idx), 3);
    step();
    chk("merge_done", int'(bus.busy), 0);

    // reset mid-drain discards pending bits and ignores req that cycle
    bus.out_ready = 1'b0;
    pulse(8'h1F);
    chk("rmd_cnt", int'(bus.pend_cnt), 4);
    rst     = 1'b1;
    bus.req = '1;
    bus.en  = 1'b1;
    step();
    rst     = 1'b0;
    bus.req = '0;
    bus.en  = 1'b0;
    chk_idle("rmd");
    chk("rmd_idx", int'(bus.out_idx), 0);
    bus.out_ready = 1'b1;
    sb.push_back(0); sb.push_back(7);
    pulse(8'h81);
    chk("rmd_first", int'(bus.out_idx), 0);
    step();
    chk("rmd_second", int'(bus.out_idx), 7);
    step();
    chk("rmd_done", int'(bus.out_valid), 0);

    chk("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
